// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows round sequencer.
// Holds the controller state encoding, display phase codes and a saturating counter helper.
package bc_pkg;

    localparam int NUM_DIGITS      = 4;
    localparam int SCAN_LEN        = 16;
    localparam int DIGIT_W_DEFAULT = 3;
    localparam int CNT_MAX         = 4;

    typedef enum logic [2:0] {
        S_SECRET,
        S_CHK_SECRET,
        S_GUESS,
        S_SCORE,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [1:0] PH_SECRET = 2'd0;
    localparam logic [1:0] PH_GUESS  = 2'd1;
    localparam logic [1:0] PH_WIN    = 2'd2;
    localparam logic [1:0] PH_LOSE   = 2'd3;

    // Bull/cow tallies stop at CNT_MAX instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic en);
        return (en && (v < 3'(CNT_MAX))) ? v + 3'd1 : v;
    endfunction

endpackage

// File: rtl/bc_pair_scanner.sv
// Sequential 16-pair comparator: one (i,j) digit pair per clock, i = idx[3:2], j = idx[1:0].
// Accumulates bulls/cows of word_a vs word_b and repeated digits within word_b; done marks the last pair.
module bc_pair_scanner
    import bc_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] word_a,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] word_b,
    output logic                          done,
    output logic                          dup,
    output logic [2:0]                    bulls,
    output logic [2:0]                    cows
);

    logic [DIGIT_W-1:0] a_dig [NUM_DIGITS];
    logic [DIGIT_W-1:0] b_dig [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign a_dig[gi] = word_a[gi*DIGIT_W +: DIGIT_W];
            assign b_dig[gi] = word_b[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    logic [3:0] idx_q, idx_d;
    logic       run_q, run_d;
    logic       dup_q, dup_d;
    logic [2:0] bulls_q, bulls_d;
    logic [2:0] cows_q, cows_d;

    logic [1:0] pair_i, pair_j;
    logic       same_pos, hit, pair_dup;
    logic       dup_sum;
    logic [2:0] bulls_sum, cows_sum;

    // The *_sum values already include the pair being examined this cycle, so on
    // the final pair the controller can commit the complete result without an extra cycle.
    always_comb begin
        pair_i    = idx_q[3:2];
        pair_j    = idx_q[1:0];
        same_pos  = (pair_i == pair_j);
        hit       = run_q && (a_dig[pair_i] == b_dig[pair_j]);
        pair_dup  = run_q && !same_pos && (b_dig[pair_i] == b_dig[pair_j]);
        dup_sum   = dup_q | pair_dup;
        bulls_sum = sat_inc(bulls_q, hit && same_pos);
        cows_sum  = sat_inc(cows_q, hit && !same_pos);
        done      = run_q && (idx_q == 4'(SCAN_LEN - 1));

        idx_d   = idx_q;
        run_d   = run_q;
        dup_d   = dup_sum;
        bulls_d = bulls_sum;
        cows_d  = cows_sum;
        if (clear) begin
            idx_d   = 4'd0;
            run_d   = 1'b0;
            dup_d   = 1'b0;
            bulls_d = 3'd0;
            cows_d  = 3'd0;
        end else if (start) begin
            idx_d   = 4'd0;
            run_d   = 1'b1;
            dup_d   = 1'b0;
            bulls_d = 3'd0;
            cows_d  = 3'd0;
        end else if (run_q) begin
            idx_d = idx_q + 4'd1;
            run_d = !done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= 4'd0;
            run_q   <= 1'b0;
            dup_q   <= 1'b0;
            bulls_q <= 3'd0;
            cows_q  <= 3'd0;
        end else begin
            idx_q   <= idx_d;
            run_q   <= run_d;
            dup_q   <= dup_d;
            bulls_q <= bulls_d;
            cows_q  <= cows_d;
        end
    end

    assign dup   = dup_sum;
    assign bulls = bulls_sum;
    assign cows  = cows_sum;

endmodule

// File: rtl/bc_game_ctrl.sv
// Bulls-and-Cows round sequencer: latches and validates the secret, scores guesses,
// counts attempts and reports win/lose status to the display formatter.
module bc_game_ctrl
    import bc_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int DIGIT_W   = DIGIT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          save,
    input  logic                          new_game,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic [2:0]                    bulls,
    output logic [2:0]                    cows,
    output logic [3:0]                    attempts,
    output logic                          result_valid,
    output logic                          dup_err,
    output logic [1:0]                    phase,
    output logic                          busy
);

    localparam int         WORD_W = NUM_DIGITS * DIGIT_W;
    localparam logic [3:0] MAX_T  = 4'(MAX_TRIES);

    state_t state_q, state_d;

    logic [WORD_W-1:0] secret_q, secret_d;
    logic [WORD_W-1:0] guess_q, guess_d;
    logic [2:0]        bulls_q, bulls_d;
    logic [2:0]        cows_q, cows_d;
    logic [3:0]        attempts_q, attempts_d;
    logic              result_valid_q, result_valid_d;
    logic              dup_err_q, dup_err_d;

    logic              scan_start, scan_done, scan_dup;
    logic [2:0]        scan_bulls, scan_cows;
    logic [WORD_W-1:0] scan_word_b;
    logic [3:0]        attempts_inc;

    assign attempts_inc = attempts_q + 4'd1;
    assign scan_start   = save && !new_game && ((state_q == S_SECRET) || (state_q == S_GUESS));
    // Secret validation compares the secret against itself; only the dup flag is used.
    assign scan_word_b  = (state_q == S_SCORE) ? guess_q : secret_q;

    bc_pair_scanner #(
        .DIGIT_W (DIGIT_W)
    ) u_scanner (
        .clk    (clk),
        .rst    (rst),
        .start  (scan_start),
        .clear  (new_game),
        .word_a (secret_q),
        .word_b (scan_word_b),
        .done   (scan_done),
        .dup    (scan_dup),
        .bulls  (scan_bulls),
        .cows   (scan_cows)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SECRET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = S_SECRET;
        end else begin
            case (state_q)
                S_SECRET:     if (save) state_d = S_CHK_SECRET;
                S_CHK_SECRET: if (scan_done) state_d = scan_dup ? S_SECRET : S_GUESS;
                S_GUESS:      if (save) state_d = S_SCORE;
                S_SCORE: begin
                    if (scan_done) begin
                        if (scan_dup)                  state_d = S_GUESS;
                        else if (scan_bulls == 3'd4)   state_d = S_WIN;
                        else if (attempts_inc == MAX_T) state_d = S_LOSE;
                        else                           state_d = S_GUESS;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        phase = PH_SECRET;
        busy  = 1'b0;
        case (state_q)
            S_CHK_SECRET: busy = 1'b1;
            S_GUESS:      phase = PH_GUESS;
            S_SCORE: begin
                phase = PH_GUESS;
                busy  = 1'b1;
            end
            S_WIN:        phase = PH_WIN;
            S_LOSE:       phase = PH_LOSE;
            default:      phase = PH_SECRET;
        endcase
    end

    // Result registers move only when a scan completes; a rejected guess leaves the score intact.
    always_comb begin
        secret_d       = secret_q;
        guess_d        = guess_q;
        bulls_d        = bulls_q;
        cows_d         = cows_q;
        attempts_d     = attempts_q;
        result_valid_d = result_valid_q;
        dup_err_d      = dup_err_q;
        if (new_game) begin
            secret_d       = '0;
            guess_d        = '0;
            bulls_d        = 3'd0;
            cows_d         = 3'd0;
            attempts_d     = 4'd0;
            result_valid_d = 1'b0;
            dup_err_d      = 1'b0;
        end else begin
            case (state_q)
                S_SECRET: if (save) secret_d = digits_in;
                S_CHK_SECRET: begin
                    if (scan_done) begin
                        dup_err_d = scan_dup;
                        if (!scan_dup) begin
                            attempts_d     = 4'd0;
                            result_valid_d = 1'b0;
                            bulls_d        = 3'd0;
                            cows_d         = 3'd0;
                        end
                    end
                end
                S_GUESS: if (save) guess_d = digits_in;
                S_SCORE: begin
                    if (scan_done) begin
                        dup_err_d = scan_dup;
                        if (!scan_dup) begin
                            bulls_d        = scan_bulls;
                            cows_d         = scan_cows;
                            result_valid_d = 1'b1;
                            attempts_d     = attempts_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secret_q       <= '0;
            guess_q        <= '0;
            bulls_q        <= 3'd0;
            cows_q         <= 3'd0;
            attempts_q     <= 4'd0;
            result_valid_q <= 1'b0;
            dup_err_q      <= 1'b0;
        end else begin
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            bulls_q        <= bulls_d;
            cows_q         <= cows_d;
            attempts_q     <= attempts_d;
            result_valid_q <= result_valid_d;
            dup_err_q      <= dup_err_d;
        end
    end

    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign attempts     = attempts_q;
    assign result_valid = result_valid_q;
    assign dup_err      = dup_err_q;

endmodule
